seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed 4-digit seven-segment driver that consumes the 16-bit display word produced by the CPU core's bus/LED-segment peripheral.
- Drives the board-level `segment_data` and `AN` pins.
- Display updates are double-buffered and committed only at frame boundaries, so a digit never shows a half-updated value.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot (50 MHz -> 1 kHz digit rate, 250 Hz frame); legal range >= 2.
- CNT_W, 16, refresh counter width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- data_in  in  16  hex value to display; digit k = data_in[4k+3:4k], digit 0 rightmost.
- dp_in  in  4  per-digit decimal point, 1 = lit; sampled together with data_in.
- load  in  1  single-cycle strobe; captures data_in/dp_in into the pending buffer.
- blank_lz  in  1  1 = blank leading zeros on digits 3..1.
- en  in  1  0 = display dark; scanning continues.
- busy  out  1  1 = pending value not yet committed.
- AN  out  4  digit anodes, active low, one-hot-low.
- segment_data  out  8  {dp,g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset (synchronous, active-high) sets:
  - refresh counter = 0, digit index = 0;
  - display_reg = 0, dp_reg = 0, pending = 0, pending_valid = 0;
  - AN = 4'b1111, segment_data = 8'hFF, busy = 0.
- Reset asserted mid-operation discards any pending value.
- Refresh counter: increments each clk from 0 to REFRESH_DIV-1, then wraps to 0. tick = (cnt == REFRESH_DIV-1).
- Digit index: advances 0->1->2->3->0 on the cycle after tick.
- Frame boundary = tick while digit index == 3.
- Load handling:
  - load with no boundary: pending <= {dp_in,data_in}; pending_valid <= 1.
  - A repeated load before commit overwrites pending (last value wins).
  - boundary with pending_valid: display_reg/dp_reg <= pending; pending_valid <= 0.
  - load in the same cycle as a boundary: display_reg/dp_reg <= data_in/dp_in directly; pending_valid <= 0. Any older pending value is dropped.
- busy = pending_valid (registered).
- Outputs are registered with 1-cycle latency from digit index/display_reg:
  - AN = ~(4'b0001 << digit);
  - segment_data = {~dp, hex code} for the current digit.
- Hex codes (dp excluded, 8-bit form with dp off):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8;
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Leading-zero blanking:
  - Applies when blank_lz = 1.
  - Digit k (k = 3..1) is blanked if digits 3..k are all zero; digit 0 is never blanked.
  - A blanked digit drives segment_data = 8'hFF, dp included; AN still cycles.
- en = 0: registered outputs are forced to AN = 4'b1111, segment_data = 8'hFF. Counter, digit index and commit logic are unaffected.
- First cycle after reset release (en = 1): AN = 4'b1110, segment_data = 8'hC0.

Decomposition:
- Package seg_pkg:
  - SEG_BLANK = 8'hFF constant;
  - 16-entry hex-to-segment constant table;
  - digit index type (2-bit).
- One combinational sub-module, hex7seg_decode: 4-bit nibble + dp + blank in, 8-bit active-low pattern out.
- Counter, scan, buffer and output registers stay in seg_scan_driver.

Test Plan:
- Reset/scan (REFRESH_DIV=4): rst 2 cycles, then en=1 → AN=1110 and segment_data=C0 on the first cycle. AN then steps 1101, 1011, 0111, 1110 every 4 cycles; segment_data=C0 throughout.
- Deferred commit: load with data_in=16'h12AF while digit=1 → busy=1, digits keep showing 0 until the frame boundary. The next frame shows 8E, 88, A4, F9 for digits 0..3, and busy=0 after the commit.
- Simultaneous load/boundary: pending=16'h1111, then load 16'h5A5A on the boundary cycle → next frame shows 5A5A, busy=0, and 1111 is never displayed.
- Leading-zero blank: blank_lz=1, data 16'h0030, dp_in=4'b1000 → digit0=C0, digit1=B0, digits 2 and 3 = FF. Digit 3's dp is suppressed.
- en gating: en=0 mid-frame → AN=1111 and segment_data=FF the next cycle. Re-enable → scan resumes at the digit implied by the free-running counter, and a load made while en=0 still commits.
- Mid-operation reset: busy=1, then assert rst → the next cycle shows AN=1111, segment_data=FF, busy=0. After release, the display shows 0000, not the pending value.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg_pkg;

  // All segments off, decimal point included (active-low pins).
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} patterns with dp off, indexed by nibble value.
  // Entry 15 is written first because this is a packed array.
  localparam logic [15:0][7:0] HEX_SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Index of the digit currently being scanned (0 = rightmost).
  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble-to-segment decoder with decimal point and blanking.
module hex7seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  // Blanking wins over everything, dp included; otherwise table pattern plus dp.
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      o_seg = {~i_dp, HEX_SEG_TABLE[i_nibble][6:0]};
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver with frame-aligned,
// double-buffered display updates.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        en,
  output logic        busy,
  output logic [3:0]  AN,
  output logic [7:0]  segment_data
);

  localparam logic [CNT_W-1:0] TICK_VAL = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  digit_idx_t       r_digit;
  logic [15:0]      r_display;
  logic [3:0]       r_dp;
  logic [19:0]      r_pending;
  logic             r_pending_valid;
  logic [3:0]       r_an;
  logic [7:0]       r_seg;

  logic             w_tick;
  logic             w_boundary;
  logic [3:0]       w_nibble;
  logic             w_dp;
  logic             w_blank;
  logic [7:0]       w_seg;

  assign w_tick     = (r_cnt == TICK_VAL);
  assign w_boundary = w_tick && (r_digit == 2'd3);

  // Free-running refresh counter, wraps after REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Digit index steps once per refresh slot, wrapping 3 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= 2'd0;
    end else if (w_tick) begin
      r_digit <= r_digit + 2'd1;
    end else begin
      r_digit <= r_digit;
    end
  end

  // Double buffer: loads park in pending and are committed only at a frame
  // boundary; a load coinciding with the boundary bypasses pending entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_display       <= 16'h0000;
      r_dp            <= 4'b0000;
      r_pending       <= 20'h00000;
      r_pending_valid <= 1'b0;
    end else if (w_boundary && load) begin
      r_display       <= data_in;
      r_dp            <= dp_in;
      r_pending_valid <= 1'b0;
    end else if (w_boundary && r_pending_valid) begin
      r_display       <= r_pending[15:0];
      r_dp            <= r_pending[19:16];
      r_pending_valid <= 1'b0;
    end else if (load) begin
      r_pending       <= {dp_in, data_in};
      r_pending_valid <= 1'b1;
    end else begin
      r_pending_valid <= r_pending_valid;
    end
  end

  // Select the nibble and decimal point of the digit being scanned.
  always_comb begin
    w_nibble = r_display[3:0];
    w_dp     = r_dp[0];
    case (r_digit)
      2'd0: begin w_nibble = r_display[3:0];   w_dp = r_dp[0]; end
      2'd1: begin w_nibble = r_display[7:4];   w_dp = r_dp[1]; end
      2'd2: begin w_nibble = r_display[11:8];  w_dp = r_dp[2]; end
      2'd3: begin w_nibble = r_display[15:12]; w_dp = r_dp[3]; end
      default: begin w_nibble = r_display[3:0]; w_dp = r_dp[0]; end
    endcase
  end

  // A digit is a leading zero when it and every digit to its left are zero;
  // the rightmost digit always shows so a zero value is still visible.
  always_comb begin
    w_blank = 1'b0;
    if (blank_lz) begin
      case (r_digit)
        2'd3:    w_blank = (r_display[15:12] == 4'h0);
        2'd2:    w_blank = (r_display[15:8]  == 8'h00);
        2'd1:    w_blank = (r_display[15:4]  == 12'h000);
        default: w_blank = 1'b0;
      endcase
    end else begin
      w_blank = 1'b0;
    end
  end

  hex7seg_decode u_decode (
    .i_nibble (w_nibble),
    .i_dp     (w_dp),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  // Registered pin drivers; en only darkens the pins, scanning carries on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else if (!en) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(4'b0001 << r_digit);
      r_seg <= w_seg;
    end
  end

  assign AN           = r_an;
  assign segment_data = r_seg;
  assign busy         = r_pending_valid;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with REFRESH_DIV = 4.
// Edge count n is measured from reset release; the pins after edge n show
// digit ((n-1)/4) % 4, and a frame boundary is the edge with n % 16 == 0.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic        en;
  logic        busy;
  logic [3:0]  AN;
  logic [7:0]  segment_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.REFRESH_DIV(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .dp_in        (dp_in),
    .load         (load),
    .blank_lz     (blank_lz),
    .en           (en),
    .busy         (busy),
    .AN           (AN),
    .segment_data (segment_data)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e);
    chk({tag, "_an"},  {12'h000, AN},          {12'h000, an_e});
    chk({tag, "_seg"}, {8'h00, segment_data},  {8'h00, seg_e});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  initial begin
    rst = 1'b1; data_in = 16'h0000; dp_in = 4'b0000;
    load = 1'b0; blank_lz = 1'b0; en = 1'b0;
    step(); step();
    chk_out("reset", 4'b1111, 8'hFF);
    chk("reset_busy", {15'h0, busy}, 16'h0000);

    // Scan after release
    rst = 1'b0; en = 1'b1; n = 0;
    run_to(1);  chk_out("scan_d0",  4'b1110, 8'hC0);
    run_to(5);  chk_out("scan_d1",  4'b1101, 8'hC0);
    run_to(9);  chk_out("scan_d2",  4'b1011, 8'hC0);
    run_to(13); chk_out("scan_d3",  4'b0111, 8'hC0);
    run_to(17); chk_out("scan_wrap", 4'b1110, 8'hC0);

    // Deferred commit: load 12AF mid-frame
    run_to(20);
    data_in = 16'h12AF; dp_in = 4'b0000; load = 1'b1;
    step(); load = 1'b0;
    chk("defer_busy", {15'h0, busy}, 16'h0001);
    run_to(24); chk_out("defer_hold1", 4'b1101, 8'hC0);
    run_to(29); chk_out("defer_hold3", 4'b0111, 8'hC0);
    run_to(32); chk("defer_busy_clr", {15'h0, busy}, 16'h0000);
    run_to(33); chk_out("defer_d0", 4'b1110, 8'h8E);
    run_to(37); chk_out("defer_d1", 4'b1101, 8'h88);
    run_to(41); chk_out("defer_d2", 4'b1011, 8'hA4);
    run_to(45); chk_out("defer_d3", 4'b0111, 8'hF9);

    // Load on the boundary overrides an older pending value
    run_to(50);
    data_in = 16'h1111; load = 1'b1;
    step(); load = 1'b0;
    chk("sim_busy", {15'h0, busy}, 16'h0001);
    run_to(63);
    data_in = 16'h5A5A; load = 1'b1;
    step(); load = 1'b0;
    chk("sim_busy_clr", {15'h0, busy}, 16'h0000);
    run_to(65); chk_out("sim_d0", 4'b1110, 8'h88);
    run_to(69); chk_out("sim_d1", 4'b1101, 8'h92);
    run_to(73); chk_out("sim_d2", 4'b1011, 8'h88);
    run_to(77); chk_out("sim_d3", 4'b0111, 8'h92);

    // Leading-zero blanking, dp on a blanked digit suppressed
    run_to(80);
    data_in = 16'h0030; dp_in = 4'b1000; blank_lz = 1'b1; load = 1'b1;
    step(); load = 1'b0;
    run_to(97);  chk_out("lz_d0", 4'b1110, 8'hC0);
    run_to(101); chk_out("lz_d1", 4'b1101, 8'hB0);
    run_to(105); chk_out("lz_d2", 4'b1011, 8'hFF);
    run_to(109); chk_out("lz_d3", 4'b0111, 8'hFF);

    // en gating, with a load made while dark
    run_to(114);
    en = 1'b0; blank_lz = 1'b0;
    data_in = 16'h0007; dp_in = 4'b0001; load = 1'b1;
    step(); load = 1'b0;
    chk_out("en_off", 4'b1111, 8'hFF);
    chk("en_off_busy", {15'h0, busy}, 16'h0001);
    run_to(125); chk_out("en_off_hold", 4'b1111, 8'hFF);
    run_to(129);
    en = 1'b1;
    step();
    chk_out("en_on_d0", 4'b1110, 8'h78);
    chk("en_on_busy", {15'h0, busy}, 16'h0000);
    run_to(134); chk_out("en_on_d1", 4'b1101, 8'hC0);

    // Reset with a pending value discards it
    run_to(136);
    data_in = 16'hBEEF; dp_in = 4'b0000; load = 1'b1;
    step(); load = 1'b0;
    chk("rst_busy_pre", {15'h0, busy}, 16'h0001);
    rst = 1'b1;
    step();
    chk_out("rst_mid", 4'b1111, 8'hFF);
    chk("rst_mid_busy", {15'h0, busy}, 16'h0000);
    rst = 1'b0; n = 0;
    run_to(1);  chk_out("rst_rel_d0", 4'b1110, 8'hC0);
    run_to(17); chk_out("rst_post_d0", 4'b1110, 8'hC0);
    run_to(21); chk_out("rst_post_d1", 4'b1101, 8'hC0);
    chk("rst_post_busy", {15'h0, busy}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
